// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin subtractor, LSB first, one bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic             br, br_nxt, d, accept, last;

  assign accept  = start && (state != RUN);
  assign last    = (idx == IW'(WIDTH - 1));
  assign d       = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt  = (~a_sh[0] & (b_sh[0] ^ br)) | (b_sh[0] & br);
  assign res_nxt = {d, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operands shift right so the bit under work is always at position 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      idx  <= '0;
      br   <= 1'b0;
      Diff <= '0;
      Bout <= 1'b0;
      zero <= 1'b1;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      idx  <= '0;
      br   <= Bin;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= res_nxt;
      br   <= br_nxt;
      idx  <= idx + 1'b1;
      if (last) begin
        Diff <= res_nxt;
        Bout <= br_nxt;
        zero <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, Bin;
  logic [W-1:0] A, B;
  logic         busy, done, Bout, zero;
  logic [W-1:0] Diff;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_diff;
  logic         last_bout, last_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, b, input logic bin);
    int v;
    v = int'(a) - int'(b) - int'(bin);
    return W'(v);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] a, b, input logic bin);
    return int'(a) < int'(b) + int'(bin);
  endfunction

  task automatic op(input logic [W-1:0] a, b, input logic bin, input bit poke, input string tag);
    logic [W-1:0] ed;
    logic         eb;
    ed = ref_diff(a, b, bin);
    eb = ref_bout(a, b, bin);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " no_done_in_run"}, done, 1'b0);
      chk({tag, " diff_hold"}, Diff, last_diff);
      chk({tag, " bout_hold"}, Bout, last_bout);
      if (poke) begin
        A = (i == 2) ? 8'hFF : W'($urandom);
        B = W'($urandom);
        Bin = 1'($urandom);
        start = (i == 2);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy_in_done"}, busy, 1'b0);
    chk({tag, " diff"}, Diff, ed);
    chk({tag, " bout"}, Bout, eb);
    chk({tag, " zero"}, zero, ed == '0);
    last_diff = ed; last_bout = eb; last_zero = (ed == '0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 1'b0);
    chk({tag, " idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] qa[$], qb[$];
    logic         qc[$];
    int           gap, got, cyc;
    logic [W-1:0] na, nb;
    logic         nc;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    last_diff = '0; last_bout = 1'b0; last_zero = 1'b1;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst diff", Diff, 0);
    chk("rst bout", Bout, 1'b0);
    chk("rst zero", zero, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(8'h5A, 8'h3C, 1'b0, 1'b0, "d5a3c");
    op(8'h00, 8'h01, 1'b0, 1'b0, "d0001");
    op(8'h10, 8'h10, 1'b1, 1'b0, "d1010b");
    op(8'h80, 8'h7F, 1'b1, 1'b0, "d807fb");
    op(8'hFF, 8'hFF, 1'b0, 1'b0, "dffff");
    op(8'h00, 8'hFF, 1'b1, 1'b0, "d00ffb");
    op(8'h12, 8'h34, 1'b0, 1'b1, "poke");
    for (int k = 0; k < 20; k++)
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");

    // Back-to-back: start held high, new operands loaded in each DONE cycle.
    @(negedge clk);
    na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
    A = na; B = nb; Bin = nc; start = 1'b1;
    qa.push_back(na); qb.push_back(nb); qc.push_back(nc);
    gap = 0; got = 0; cyc = 0;
    while (got < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++; gap++;
      if (done) begin
        chk("b2b gap", gap, W + 1);
        chk("b2b diff", Diff, ref_diff(qa[0], qb[0], qc[0]));
        chk("b2b bout", Bout, ref_bout(qa[0], qb[0], qc[0]));
        last_diff = ref_diff(qa[0], qb[0], qc[0]);
        last_bout = ref_bout(qa[0], qb[0], qc[0]);
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
        got++; gap = 0;
        na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
        A = na; B = nb; Bin = nc;
        qa.push_back(na); qb.push_back(nb); qc.push_back(nc);
      end
    end
    chk("b2b count", got, 6);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Reset three cycles into RUN.
    A = 8'h5A; B = 8'h3C; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst busy", busy, 1'b0);
    chk("mid_rst done", done, 1'b0);
    chk("mid_rst diff", Diff, 0);
    chk("mid_rst bout", Bout, 1'b0);
    chk("mid_rst zero", zero, 1'b1);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_start_ignored", busy, 1'b0);
    start = 1'b0;
    rst = 1'b0;
    last_diff = '0; last_bout = 1'b0; last_zero = 1'b1;
    got = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || busy) got++;
    end
    chk("no_done_after_rst", got, 0);
    op(8'h80, 8'h7F, 1'b1, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
